// File: rtl/matrix_arbiter_lock.sv
// Least-recently-granted matrix arbiter with packet-level grant locking.
// A granted head flit locks the output to its channel until the tail flit
// transfers; priority is only rotated when a packet completes on a real
// transfer (gnt_valid & out_ready), so back-pressure never disturbs fairness.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   req        per-channel request (flit valid)
//   tail       per-channel tail-flit marker, qualified by req
//   out_ready  downstream accepts the granted flit this cycle
//   gnt        one-hot grant, combinational from req and state
//   gnt_valid  OR of gnt
//   gnt_idx    binary index of gnt, 0 when nothing is granted
//   locked     registered; a packet is in progress
module matrix_arbiter_lock #(
    parameter int unsigned N       = 5,
    parameter bit          LOCK_EN = 1'b1,
    localparam int unsigned IDW    = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   tail,
    input  logic           out_ready,
    output logic [N-1:0]   gnt,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_idx,
    output logic           locked
);

    localparam int unsigned NPAIR = N * (N - 1) / 2;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t               state;
    logic [IDW-1:0]       owner;
    logic [NPAIR-1:0]     mat;        // bit for pair (i>j): 1 = i beats j
    logic [NPAIR-1:0]     mat_nxt;    // matrix with the current winner demoted
    logic [N-1:0][N-1:0]  beats;      // beats[i][j]: i wins over j (diag = 1)
    logic [N-1:0]         arb_gnt;
    logic [N-1:0]         own_hot;
    logic                 xfer;
    logic                 tail_hit;

    // Expand the triangular matrix into a full beats table and compute the
    // demoted matrix: the granted channel loses to everyone else.
    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            if (gi == gj) begin : g_diag
                assign beats[gi][gj] = 1'b1;
            end else if (gi > gj) begin : g_low
                localparam int unsigned P = gi * (gi - 1) / 2 + gj;
                assign beats[gi][gj] = mat[P];
                assign mat_nxt[P]    = gnt[gi] ? 1'b0 : (gnt[gj] ? 1'b1 : mat[P]);
            end else begin : g_high
                localparam int unsigned P = gj * (gj - 1) / 2 + gi;
                assign beats[gi][gj] = ~mat[P];
            end
        end

        // Win iff requesting and beating every other requester.
        assign arb_gnt[gi] = req[gi] & (&(~req | beats[gi]));
        assign own_hot[gi] = (owner == IDW'(gi));
    end

    // Grant select; the lock ignores every channel except the owner.
    always_comb begin
        gnt = '0;
        if (!rst) begin
            gnt = (state == S_LOCKED) ? (req & own_hot) : arb_gnt;
        end
    end

    assign gnt_valid = |gnt;

    // One-hot to binary.
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                gnt_idx = gnt_idx | IDW'(i);
            end
        end
    end

    assign xfer     = gnt_valid & out_ready;
    assign tail_hit = |(gnt & tail);

    // Lock FSM and priority matrix; nothing moves without a transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            mat    <= '1;
            state  <= S_IDLE;
            owner  <= '0;
            locked <= 1'b0;
        end else if (xfer) begin
            case (state)
                S_IDLE: begin
                    if (tail_hit || !LOCK_EN) begin
                        mat <= mat_nxt;
                    end else begin
                        owner  <= gnt_idx;
                        state  <= S_LOCKED;
                        locked <= 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (tail_hit) begin
                        mat    <= mat_nxt;
                        state  <= S_IDLE;
                        locked <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_arbiter_lock.sv
// Bench for matrix_arbiter_lock: one locking and one flit-level instance share
// stimulus; a priority-list model predicts both every cycle.
module tb_matrix_arbiter_lock;

    localparam int N = 5;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] tail;
    logic         out_ready;

    logic [N-1:0] gnt0, gnt1;
    logic         gv0, gv1;
    logic [2:0]   gi0, gi1;
    logic         lk0, lk1;

    int total;
    int passed;

    // Model: ord[m][0] is highest priority; winner moves to the end.
    int ord  [2][N];
    bit mlk  [2];
    int mown [2];
    bit men  [2];

    matrix_arbiter_lock #(.N(N), .LOCK_EN(1'b1)) u_lock (
        .clk(clk), .rst(rst), .req(req), .tail(tail), .out_ready(out_ready),
        .gnt(gnt0), .gnt_valid(gv0), .gnt_idx(gi0), .locked(lk0)
    );

    matrix_arbiter_lock #(.N(N), .LOCK_EN(1'b0)) u_flit (
        .clk(clk), .rst(rst), .req(req), .tail(tail), .out_ready(out_ready),
        .gnt(gnt1), .gnt_valid(gv1), .gnt_idx(gi1), .locked(lk1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] mexp(input int m);
        logic [N-1:0] g;
        g = '0;
        if (rst) return g;
        if (mlk[m]) begin
            if (req[mown[m]]) g[mown[m]] = 1'b1;
            return g;
        end
        for (int k = 0; k < N; k++) begin
            if (req[ord[m][k]]) begin
                g[ord[m][k]] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    function automatic int idx_of(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return 0;
    endfunction

    task automatic demote(input int m, input int w);
        int p;
        p = 0;
        for (int k = 0; k < N; k++) if (ord[m][k] == w) p = k;
        for (int k = p; k < N - 1; k++) ord[m][k] = ord[m][k + 1];
        ord[m][N - 1] = w;
    endtask

    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            logic [N-1:0] g;
            int w;
            g = mexp(m);
            w = idx_of(g);
            if (rst) begin
                for (int k = 0; k < N; k++) ord[m][k] = N - 1 - k;
                mlk[m]  = 1'b0;
                mown[m] = 0;
            end else if (g != '0 && out_ready) begin
                if (mlk[m]) begin
                    if (tail[w]) begin
                        demote(m, w);
                        mlk[m] = 1'b0;
                    end
                end else if (tail[w] || !men[m]) begin
                    demote(m, w);
                end else begin
                    mlk[m]  = 1'b1;
                    mown[m] = w;
                end
            end
        end
    endtask

    task automatic compare();
        logic [N-1:0] e0, e1;
        e0 = mexp(0);
        e1 = mexp(1);
        chk("lock_gnt",       32'(gnt0), 32'(e0));
        chk("lock_gnt_valid", 32'(gv0),  32'(e0 != '0));
        chk("lock_gnt_idx",   32'(gi0),  32'(idx_of(e0)));
        chk("lock_locked",    32'(lk0),  32'(mlk[0]));
        chk("flit_gnt",       32'(gnt1), 32'(e1));
        chk("flit_gnt_valid", 32'(gv1),  32'(e1 != '0));
        chk("flit_gnt_idx",   32'(gi1),  32'(idx_of(e1)));
        chk("flit_locked",    32'(lk1),  32'(mlk[1]));
    endtask

    // Apply inputs just after a falling edge and check the model.
    task automatic cyc(input logic r, input logic [N-1:0] q, input logic [N-1:0] t,
                       input logic rd);
        rst       = r;
        req       = q;
        tail      = t;
        out_ready = rd;
        #1;
        compare();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        int e1 [6];
        int e6 [4];
        total  = 0;
        passed = 0;
        men[0] = 1'b1;
        men[1] = 1'b0;
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < N; k++) ord[m][k] = N - 1 - k;
            mlk[m]  = 1'b0;
            mown[m] = 0;
        end
        rst = 1'b1; req = '0; tail = '0; out_ready = 1'b0;
        @(negedge clk);

        // Reset with everything requesting: outputs forced low.
        cyc(1'b1, 5'b11111, 5'b11111, 1'b1);
        chk("rst_gnt", 32'(gnt0), 32'd0);
        tick();
        cyc(1'b1, 5'b00000, 5'b00000, 1'b1);
        chk("rst_locked", 32'(lk0), 32'd0);
        tick();

        // Single-flit packets rotate through all channels.
        e1 = '{4, 3, 2, 1, 0, 4};
        for (int c = 0; c < 6; c++) begin
            cyc(1'b0, 5'b11111, 5'b11111, 1'b1);
            chk("p1_idx", 32'(gi0), 32'(e1[c]));
            chk("p1_locked", 32'(lk0), 32'd0);
            tick();
        end

        // Four-flit packet on channel 4 holds off channel 0 and 1.
        cyc(1'b1, 5'b00000, 5'b00000, 1'b0);
        tick();
        for (int c = 0; c < 4; c++) begin
            cyc(1'b0, (c == 1) ? 5'b10011 : 5'b10001, (c == 3) ? 5'b10000 : 5'b00000, 1'b1);
            chk("p2_gnt", 32'(gnt0), 32'b10000);
            chk("p2_locked", 32'(lk0), (c == 0) ? 32'd0 : 32'd1);
            tick();
        end
        cyc(1'b0, 5'b00011, 5'b00011, 1'b1);
        chk("p2_next_idx", 32'(gi0), 32'd1);
        tick();

        // Back-pressure mid-packet freezes the lock on channel 3.
        cyc(1'b0, 5'b01000, 5'b00000, 1'b1);
        tick();
        for (int c = 0; c < 5; c++) begin
            cyc(1'b0, 5'b01000, 5'b00000, 1'b0);
            chk("p3_gnt", 32'(gnt0), 32'b01000);
            chk("p3_locked", 32'(lk0), 32'd1);
            tick();
        end
        cyc(1'b0, 5'b01000, 5'b01000, 1'b1);
        chk("p3_resume", 32'(gnt0), 32'b01000);
        tick();

        // Owner 2 drops its request: nobody else may take the output.
        cyc(1'b0, 5'b00100, 5'b00000, 1'b1);
        tick();
        for (int c = 0; c < 2; c++) begin
            cyc(1'b0, 5'b11001, 5'b11001, 1'b1);
            chk("p4_gnt", 32'(gnt0), 32'd0);
            chk("p4_valid", 32'(gv0), 32'd0);
            chk("p4_locked", 32'(lk0), 32'd1);
            tick();
        end
        cyc(1'b0, 5'b11101, 5'b00100, 1'b1);
        chk("p4_restore", 32'(gnt0), 32'b00100);
        tick();

        // Reset abandons a lock held by channel 1.
        cyc(1'b0, 5'b00010, 5'b00000, 1'b1);
        chk("p5_lockgnt", 32'(gnt0), 32'b00010);
        tick();
        cyc(1'b1, 5'b00011, 5'b00000, 1'b1);
        chk("p5_rst_gnt", 32'(gnt0), 32'd0);
        chk("p5_rst_valid", 32'(gv0), 32'd0);
        tick();
        cyc(1'b0, 5'b00011, 5'b00011, 1'b1);
        chk("p5_locked", 32'(lk0), 32'd0);
        chk("p5_idx", 32'(gi0), 32'd1);
        tick();

        // Flit-level instance alternates without ever locking.
        cyc(1'b1, 5'b00000, 5'b00000, 1'b0);
        tick();
        e6 = '{2, 0, 2, 0};
        for (int c = 0; c < 4; c++) begin
            cyc(1'b0, 5'b00101, 5'b00000, 1'b1);
            chk("p6_idx", 32'(gi1), 32'(e6[c]));
            chk("p6_locked", 32'(lk1), 32'd0);
            tick();
        end

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            logic         r;
            logic [N-1:0] q;
            logic [N-1:0] t;
            logic         rd;
            r  = ($urandom_range(0, 63) == 0);
            q  = N'($urandom);
            t  = N'($urandom & $urandom);
            rd = ($urandom_range(0, 3) != 0);
            cyc(r, q, t, rd);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
